// File: rtl/rf_seq_if.sv
// Bus bundle between the instruction fetch/execute side and the rf_seq sequencer.
// The master modport drives instructions, results and done; the slave modport is the sequencer.
interface rf_seq_if;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] result;
   logic        result_valid;
   logic        rf_done;
   logic [4:0]  Rx;
   logic [4:0]  Ry;
   logic [4:0]  Rz;
   logic [5:0]  opcode;
   logic [31:0] data;
   logic        set;
   logic        wrt;
   logic        busy;
   logic        err;

   modport master (
      output instr, instr_valid, result, result_valid, rf_done,
      input  instr_ready, Rx, Ry, Rz, opcode, data, set, wrt, busy, err
   );

   modport slave (
      input  instr, instr_valid, result, result_valid, rf_done,
      output instr_ready, Rx, Ry, Rz, opcode, data, set, wrt, busy, err
   );
endinterface

// File: rtl/rf_seq.sv
// Register-file sequencer: accepts one instruction, clears the RF done flag, optionally waits
// for an execute result, then writes or waits for done with a sticky timeout error.
module rf_seq #(
   parameter int unsigned DONE_TIMEOUT = 15
) (
   input logic    clk,
   input logic    rst_n,
   rf_seq_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StClear, StRead, StExec, StWrite, StWait} state_e;

   state_e      state_q, state_d;
   logic [5:0]  opcode_q, opcode_d;
   logic [4:0]  rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
   logic [15:0] imm_q, imm_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic [4:0]  cnt_inc;
   logic        timeout;

   assign cnt_inc = {1'b0, cnt_q} + 5'd1;
   assign timeout = (cnt_inc == 5'(DONE_TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         opcode_q <= '0;
         rx_q     <= '0;
         ry_q     <= '0;
         rz_q     <= '0;
         imm_q    <= '0;
         data_q   <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         rx_q     <= rx_d;
         ry_q     <= ry_d;
         rz_q     <= rz_d;
         imm_q    <= imm_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      rx_d     = rx_q;
      ry_d     = ry_q;
      rz_d     = rz_q;
      imm_d    = imm_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      err_d    = err_q;

      unique case (state_q)
         StIdle: begin
            if (bus.instr_valid) begin
               opcode_d = bus.instr[31:26];
               rz_d     = bus.instr[25:21];
               rx_d     = bus.instr[20:16];
               ry_d     = bus.instr[15:11];
               imm_d    = bus.instr[15:0];
               state_d  = StClear;
            end
         end
         StClear: begin
            cnt_d   = '0;
            state_d = StRead;
         end
         StRead: begin
            if (opcode_q == 6'd13 || opcode_q == 6'd14) begin
               state_d = StWait;
            end else if (opcode_q == 6'd10) begin
               data_d  = {16'h0000, imm_q};
               state_d = StWrite;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            if (bus.result_valid) begin
               data_d  = bus.result;
               state_d = StWrite;
            end
         end
         StWrite, StWait: begin
            if (bus.rf_done) begin
               state_d = StIdle;
            end else begin
               // Saturate so a stalled RF can never wrap the counter.
               if (cnt_q != 4'hF) cnt_d = cnt_inc[3:0];
               if (timeout) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.busy        = (state_q != StIdle);
   assign bus.instr_ready = (state_q == StIdle);
   assign bus.set         = (state_q == StClear);
   assign bus.wrt         = (state_q == StWrite);
   assign bus.err         = err_q;
   assign bus.opcode      = opcode_q;
   assign bus.Rx          = rx_q;
   assign bus.Ry          = ry_q;
   assign bus.Rz          = rz_q;
   assign bus.data        = data_q;

endmodule
